// File: rtl/fetch_sequencer_pkg.sv
// definitions: shared package for the fetch path.
//   DATA_WIDTH        width of fetch destination / branch target
//   START_ADDRESS     PC value the fetch stage loads on its reset
//   fetch_seq_state_t control state of fetch_sequencer
package definitions;

  localparam int              DATA_WIDTH    = 8;
  localparam logic [DATA_WIDTH-1:0] START_ADDRESS = '0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    FETCH    = 3'd2,
    REDIRECT = 3'd3,
    FLUSH    = 3'd4,
    HALTED   = 3'd5
  } fetch_seq_state_t;

endpackage

// File: rtl/fetch_sequencer_sat.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   _CLK     clock
//   _clear   synchronous clear, wins over _enable
//   _enable  count this cycle
//   _count   current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             _CLK,
  input  logic             _clear,
  input  logic             _enable,
  output logic [WIDTH-1:0] _count
);

  always_ff @(posedge _CLK) begin
    if (_clear)
      _count <= '0;
    else if (_enable && (_count != {WIDTH{1'b1}}))
      _count <= _count + WIDTH'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: turns start/stall/branch/halt events into a legal
// per-cycle command stream for the fetch stage. At most one of run,
// reset, branch/jump is active in any cycle.
//   _CLK, _reset                      clock, sync active-high reset
//   _start, _stall                    begin execution / downstream stall
//   _branchReq, _branchRelative,
//   _branchTarget                     redirect request from execute
//   _haltReq                          halt decoded
//   _fetchRun/_fetchReset/_fetchHalt/
//   _fetchBranchJump/_fetchRelative/
//   _fetchDest                        fetch stage controls
//   _busy, _done                      status
//   _fetchCount                       saturating count of issued fetches
module fetch_sequencer
  import definitions::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   _CLK,
  input  logic                   _reset,
  input  logic                   _start,
  input  logic                   _stall,
  input  logic                   _branchReq,
  input  logic                   _branchRelative,
  input  logic [DATA_WIDTH-1:0]  _branchTarget,
  input  logic                   _haltReq,
  output logic                   _fetchRun,
  output logic                   _fetchReset,
  output logic                   _fetchHalt,
  output logic                   _fetchBranchJump,
  output logic                   _fetchRelative,
  output logic [DATA_WIDTH-1:0]  _fetchDest,
  output logic                   _busy,
  output logic                   _done,
  output logic [COUNT_WIDTH-1:0] _fetchCount
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  fetch_seq_state_t      state;
  logic [FW-1:0]         flush_cnt;
  logic                  cap_rel;
  logic [DATA_WIDTH-1:0] cap_dest;
  logic                  reset_q, halt_q, bj_q, busy_q, done_q;

  // Only combinational input-to-output path: stall/halt/branch veto run.
  assign _fetchRun = (state == FETCH) && !_stall && !_haltReq && !_branchReq;

  assign _fetchReset     = reset_q;
  assign _fetchHalt      = halt_q;
  assign _fetchBranchJump = bj_q;
  assign _fetchRelative  = bj_q & cap_rel;
  assign _fetchDest      = bj_q ? cap_dest : '0;
  assign _busy           = busy_q;
  assign _done           = done_q;

  // Output flops are written with the value belonging to the state being
  // entered, so they track the state register exactly.
  always_ff @(posedge _CLK) begin
    if (_reset) begin
      state     <= IDLE;
      flush_cnt <= '0;
      cap_rel   <= 1'b0;
      cap_dest  <= '0;
      reset_q   <= 1'b0;
      halt_q    <= 1'b0;
      bj_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      reset_q <= 1'b0;
      halt_q  <= 1'b0;
      bj_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (_start) begin
            state   <= CLEAR;
            reset_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          state  <= FETCH;
          busy_q <= 1'b1;
        end
        FETCH: begin
          if (_haltReq) begin
            state  <= HALTED;
            halt_q <= 1'b1;
            done_q <= 1'b1;
          end else if (_branchReq) begin
            state    <= REDIRECT;
            cap_rel  <= _branchRelative;
            cap_dest <= _branchTarget;
            bj_q     <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            busy_q <= 1'b1;
          end
        end
        REDIRECT: begin
          busy_q <= 1'b1;
          if (FLUSH_CYCLES == 0) begin
            state <= FETCH;
          end else begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          // Pipeline is squashed: branch/halt/start are ignored here.
          busy_q <= 1'b1;
          if (flush_cnt == '0)
            state <= FETCH;
          else
            flush_cnt <= flush_cnt - FW'(1);
        end
        HALTED: begin
          if (_start) begin
            state   <= CLEAR;
            reset_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            halt_q <= 1'b1;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Cleared on entry to CLEAR so the count already reads 0 during CLEAR.
  logic cnt_clear;
  assign cnt_clear = _reset || (state == CLEAR) ||
                     (((state == IDLE) || (state == HALTED)) && _start);

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_fetch_cnt (
    ._CLK    (_CLK),
    ._clear  (cnt_clear),
    ._enable (_fetchRun),
    ._count  (_fetchCount)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  import definitions::*;

  logic                  clk = 1'b0;
  logic                  rst, start, stall, breq, brel, hreq;
  logic [DATA_WIDTH-1:0] btgt;
  logic                  run, freset, fhalt, bj, frel, busy, done;
  logic [DATA_WIDTH-1:0] fdest;
  logic [3:0]            fcnt;

  int checks = 0;
  int errors = 0;
  int bj_pulses = 0;

  fetch_sequencer #(.FLUSH_CYCLES(1), .COUNT_WIDTH(4)) dut (
    ._CLK            (clk),
    ._reset          (rst),
    ._start          (start),
    ._stall          (stall),
    ._branchReq      (breq),
    ._branchRelative (brel),
    ._branchTarget   (btgt),
    ._haltReq        (hreq),
    ._fetchRun       (run),
    ._fetchReset     (freset),
    ._fetchHalt      (fhalt),
    ._fetchBranchJump(bj),
    ._fetchRelative  (frel),
    ._fetchDest      (fdest),
    ._busy           (busy),
    ._done           (done),
    ._fetchCount     (fcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then applied 2 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // One-hot invariant on run/reset/branch-jump, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert ((32'(run) + 32'(freset) + 32'(bj)) <= 32'd1) else begin
        errors++;
        $error("FAIL onehot observed=%0d%0d%0d expected=at-most-one", run, freset, bj);
      end
    end
    if (bj === 1'b1) bj_pulses++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; stall = 0; breq = 0; brel = 0; hreq = 0; btgt = '0;
    cyc(); cyc();
    #1;
    chk("rst_run", {31'b0, run}, 0);
    chk("rst_freset", {31'b0, freset}, 0);
    chk("rst_halt", {31'b0, fhalt}, 0);
    chk("rst_bj", {31'b0, bj}, 0);
    chk("rst_busy_done", {30'b0, busy, done}, 0);
    chk("rst_cnt", {28'b0, fcnt}, 0);

    // start -> CLEAR -> FETCH
    rst = 0; start = 1;
    cyc(); start = 0; #1;
    chk("clear_freset", {31'b0, freset}, 1);
    chk("clear_run", {31'b0, run}, 0);
    chk("clear_busy", {31'b0, busy}, 1);
    cyc(); #1;
    for (int i = 0; i < 5; i++) begin
      chk("fetch_run", {31'b0, run}, 1);
      cyc(); #1;
    end
    chk("cnt5", {28'b0, fcnt}, 5);
    chk("busy5", {31'b0, busy}, 1);

    // relative branch to 8'hFC
    breq = 1; brel = 1; btgt = 8'hFC; #1;
    chk("breq_run", {31'b0, run}, 0);
    cyc(); breq = 0; brel = 0; btgt = '0; #1;
    chk("redir_bj", {31'b0, bj}, 1);
    chk("redir_rel", {31'b0, frel}, 1);
    chk("redir_dest", {24'b0, fdest}, 32'hFC);
    chk("redir_run", {31'b0, run}, 0);
    cyc(); #1;
    chk("flush_bj", {31'b0, bj}, 0);
    chk("flush_run", {31'b0, run}, 0);
    chk("flush_busy", {31'b0, busy}, 1);
    cyc(); #1;
    chk("postbr_run", {31'b0, run}, 1);
    chk("postbr_cnt", {28'b0, fcnt}, 5);
    cyc(); #1;
    chk("cnt6", {28'b0, fcnt}, 6);

    // 3 stalled cycles
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_run", {31'b0, run}, 0);
      cyc();
    end
    #1;
    chk("stall_cnt", {28'b0, fcnt}, 6);
    chk("stall_busy", {31'b0, busy}, 1);
    // stall + absolute branch to 8'h40
    breq = 1; brel = 0; btgt = 8'h40; #1;
    chk("stallbr_run", {31'b0, run}, 0);
    cyc(); breq = 0; stall = 0; btgt = '0; #1;
    chk("stallbr_bj", {31'b0, bj}, 1);
    chk("stallbr_dest", {24'b0, fdest}, 32'h40);
    chk("stallbr_rel", {31'b0, frel}, 0);
    cyc(); cyc(); #1;
    chk("stallbr_resume", {31'b0, run}, 1);

    // halt + branch together -> HALTED, no branch
    bj_pulses = 0;
    hreq = 1; breq = 1; btgt = 8'h11; #1;
    chk("halt_run", {31'b0, run}, 0);
    cyc(); hreq = 0; breq = 0; #1;
    chk("halted_halt", {31'b0, fhalt}, 1);
    chk("halted_done", {31'b0, done}, 1);
    chk("halted_busy", {31'b0, busy}, 0);
    chk("halted_bj", {31'b0, bj}, 0);
    cyc(); #1;
    chk("halted_hold", {31'b0, fhalt}, 1);
    chk("halt_no_bj", 32'(bj_pulses), 0);
    start = 1;
    cyc(); start = 0; #1;
    chk("restart_freset", {31'b0, freset}, 1);
    chk("restart_cnt", {28'b0, fcnt}, 0);
    chk("restart_done", {31'b0, done}, 0);
    cyc(); #1;
    chk("restart_run", {31'b0, run}, 1);

    // reset during REDIRECT
    breq = 1; brel = 1; btgt = 8'h33;
    cyc(); breq = 0; #1;
    chk("rr_bj", {31'b0, bj}, 1);
    rst = 1;
    cyc(); rst = 0; #1;
    chk("rr_bj0", {31'b0, bj}, 0);
    chk("rr_dest0", {24'b0, fdest}, 0);
    chk("rr_busy", {31'b0, busy}, 0);
    chk("rr_cnt", {28'b0, fcnt}, 0);
    cyc(); #1;
    chk("rr_idle_run", {31'b0, run}, 0);
    chk("rr_idle_freset", {31'b0, freset}, 0);

    // branch/halt in FLUSH ignored, exactly one branch pulse
    start = 1;
    cyc(); start = 0;
    cyc();
    bj_pulses = 0;
    breq = 1; brel = 0; btgt = 8'h12;
    cyc(); breq = 0; #1;
    chk("fl_bj", {31'b0, bj}, 1);
    cyc(); breq = 1; hreq = 1; btgt = 8'h99; #1;
    chk("fl_ign_run", {31'b0, run}, 0);
    cyc(); breq = 0; hreq = 0; #1;
    chk("fl_ign_bj", {31'b0, bj}, 0);
    chk("fl_ign_halt", {31'b0, fhalt}, 0);
    chk("fl_resume_run", {31'b0, run}, 1);
    cyc(); cyc(); #1;
    chk("fl_pulses", 32'(bj_pulses), 1);

    // saturation: restart, 20 unstalled fetches
    rst = 1; cyc(); rst = 0;
    start = 1; cyc(); start = 0;
    cyc();
    for (int i = 0; i < 20; i++) cyc();
    #1;
    chk("sat_cnt", {28'b0, fcnt}, 15);
    chk("sat_run", {31'b0, run}, 1);
    cyc(); cyc(); #1;
    chk("sat_hold", {28'b0, fcnt}, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that drives the instruction fetch stage's control inputs: run, reset, halt, branch/jump, relative and destination.
- Sits between decode/execute and the fetch stage.
- Turns start, stall, branch-request and halt-request events into a legal per-cycle command stream.
- Guarantees at most one of run, reset or branch/jump is asserted in any cycle, and counts issued fetches.

Parameters:
- FLUSH_CYCLES, 1: bubble cycles after a redirect before fetch resumes; 0 returns straight to FETCH.
- COUNT_WIDTH, 16: width of the issued-fetch counter.

Ports:
- _CLK  input  1  clock; all state updates on posedge.
- _reset  input  1  synchronous, active-high reset.
- _start  input  1  begin/restart program execution; honoured in IDLE and HALTED only.
- _stall  input  1  downstream cannot accept an instruction this cycle.
- _branchReq  input  1  execute stage requests a PC redirect.
- _branchRelative  input  1  redirect is PC-relative (signed offset) when 1, absolute when 0.
- _branchTarget  input  DATA_WIDTH  redirect offset or absolute address.
- _haltReq  input  1  halt instruction decoded.
- _fetchRun  output  1  to fetch stage run.
- _fetchReset  output  1  to fetch stage reset (PC <- START_ADDRESS).
- _fetchHalt  output  1  to fetch stage halt.
- _fetchBranchJump  output  1  to fetch stage branch/jump.
- _fetchRelative  output  1  to fetch stage relative.
- _fetchDest  output  DATA_WIDTH  to fetch stage destination.
- _busy  output  1  state is not IDLE and not HALTED.
- _done  output  1  state is HALTED.
- _fetchCount  output  COUNT_WIDTH  fetch cycles issued since the last CLEAR; saturating.

Behaviour:
- Reset: synchronous, active-high, highest priority in every state. Produces state=IDLE, capture registers=0, flush counter=0, _fetchCount=0, and every output 0.
- States are IDLE, CLEAR, FETCH, REDIRECT, FLUSH, HALTED.
- All outputs decode from registered state and capture registers, except _fetchRun. _fetchRun = (state==FETCH) && !_stall && !_haltReq && !_branchReq, with no other input-to-output path.
- IDLE: all outputs 0. _start -> CLEAR next cycle.
- CLEAR (1 cycle): _fetchReset=1 and all other fetch controls 0; _fetchCount cleared; -> FETCH.
- FETCH, in priority order:
  - _haltReq -> HALTED.
  - else _branchReq -> REDIRECT, capturing _branchTarget and _branchRelative into registers.
  - else stay in FETCH.
  - _stall only suppresses _fetchRun; it never blocks halt or redirect. _start is ignored.
- REDIRECT (1 cycle): _fetchBranchJump=1, _fetchRelative and _fetchDest from the capture registers, run=0. Then -> FLUSH, or -> FETCH if FLUSH_CYCLES==0.
- FLUSH: all fetch controls 0 for exactly FLUSH_CYCLES cycles (counter loaded on entry), then -> FETCH. _branchReq, _haltReq and _start are ignored (the pipeline is squashed).
- HALTED: _fetchHalt=1, _done=1, all other fetch controls 0. _start -> CLEAR; otherwise hold.
- _fetchCount increments on every cycle _fetchRun=1 and saturates at 2^COUNT_WIDTH-1 with no wrap.
- Invariant: _fetchRun + _fetchReset + _fetchBranchJump <= 1 every cycle.
- Latency:
  - _start to first _fetchRun: 2 cycles (CLEAR, then FETCH).
  - Branch request to first post-redirect _fetchRun: 2+FLUSH_CYCLES cycles.
- Reset asserted mid-REDIRECT or mid-FLUSH: IDLE next cycle, capture registers zeroed, no branch command issued.

Decomposition:
- Shared package `definitions` holds DATA_WIDTH and START_ADDRESS (already present) plus a new enum typedef fetch_seq_state_t (IDLE, CLEAR, FETCH, REDIRECT, FLUSH, HALTED; 3-bit encoding).
- One sub-module is natural: sat_counter (parameterised width, synchronous clear, enable, saturate), used for _fetchCount.
- The flush counter stays inline.

Test Plan:
- Bench configuration: DATA_WIDTH=8, START_ADDRESS=0, FLUSH_CYCLES=1.
- _reset 2 cycles, then _start pulse -> cycle 1 _fetchReset=1; cycle 2 onward _fetchRun=1; after 5 FETCH cycles _fetchCount=5, _busy=1.
- In FETCH, _branchReq=1, _branchRelative=1, _branchTarget=8'hFC for one cycle -> that cycle _fetchRun=0. Next cycle _fetchBranchJump=1, _fetchRelative=1, _fetchDest=8'hFC. Then 1 bubble, then _fetchRun=1.
- _stall=1 for 3 FETCH cycles -> _fetchRun=0 for those 3, _fetchCount unchanged, state stays FETCH. Same-cycle _stall+_branchReq (target 8'h40, absolute) -> REDIRECT with _fetchDest=8'h40, _fetchRelative=0.
- _haltReq and _branchReq together in FETCH -> HALTED next cycle (_fetchHalt=1, _done=1), no _fetchBranchJump ever. Later _start -> CLEAR, _fetchCount=0.
- _reset asserted during REDIRECT -> next cycle IDLE, all outputs 0. _branchReq during FLUSH is ignored, with exactly one _fetchBranchJump pulse observed.
- COUNT_WIDTH=4, run 20 unstalled fetches -> _fetchCount reaches 15 and holds; the one-hot invariant on run/reset/branch/jump is checked every cycle by assertion.
